// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures fetch PC/instruction, inserts redirect and fusion bubbles, holds on stall.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module if_id_pipe_reg #(
  parameter int              XLEN        = 32,
  parameter int              FLUSH_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(32'h00000013),
  parameter logic [XLEN-1:0] KILL_INSTR  = XLEN'(32'h00000000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            jump,
  input  logic            branch_taken,
  input  logic            jalr,
  input  logic            stall,
  input  logic            fuse_flush,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            valid_out,
  output logic            flushing,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     stall_cnt
);

  localparam int CNT_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  redirect;

  assign redirect = jump | branch_taken | jalr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= KILL_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = '0;
      instr_d = KILL_INSTR;
      valid_d = 1'b0;
      // A redirect during FLUSH reloads the count, extending the bubble window.
      if (FLUSH_DEPTH > 0) begin
        state_d = FLUSH;
        cnt_d   = CNT_W'(FLUSH_DEPTH);
      end
    end else if (state_q == FLUSH) begin
      pc_d    = '0;
      instr_d = KILL_INSTR;
      valid_d = 1'b0;
      cnt_d   = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) state_d = IDLE;
    end else if (fuse_flush) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;
  assign flushing  = (state_q == FLUSH);

`ifdef PERF_CNT_EN
  logic [31:0] flush_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_hold;

  // Only a genuine hold counts; stalls masked by redirect, FLUSH or fusion do not.
  assign stall_hold = stall & ~redirect & ~fuse_flush & (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redirect && (flush_cnt_q != 32'hFFFFFFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (stall_hold && (stall_cnt_q != 32'hFFFFFFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign flush_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule
